cache_fill_arbiter: RTL and testbench

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

---
 rtl/cache_fill_arbiter_pkg.sv | 25 ++
 rtl/cache_fill_arbiter_fill_word_counter.sv | 38 +++
 rtl/cache_fill_arbiter.sv | 138 +++++++++++++
 tb/tb_cache_fill_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_arbiter_pkg.sv
// Shared CPU definitions for the cache refill path: block geometry, FSM encoding
// and the cache-select tag carried through a fill transaction.
package cache_fill_arbiter_pkg;

    localparam int          BLOCK_WORDS = 8;
    localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fillState_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_I    = 2'd1,
        SEL_D    = 2'd2
    } cacheSel_e;

    // Byte address of word idx inside the block at base; wraps modulo 2^16.
    function automatic logic [15:0] wordAddr(input logic [15:0] base, input logic [2:0] idx);
        return base + {12'd0, idx, 1'b0};
    endfunction

endpackage

// File: rtl/cache_fill_arbiter_fill_word_counter.sv
// Word index within a block fill: synchronous clear, increment, and a flag
// raised while the count sits on the last word of the block.
module fill_word_counter
    import cache_fill_arbiter_pkg::*;
#(
    parameter int WORDS = BLOCK_WORDS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [2:0] count_o,
    output logic       terminal_o
);

    logic [2:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign terminal_o = (count_q == 3'(WORDS - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Refills one 16-byte block at a time into the I- or D-cache from a pipelined
// main memory; D misses take priority, and a block always completes once started.
module cache_fill_arbiter #(
    parameter int BLOCK_WORDS = cache_fill_arbiter_pkg::BLOCK_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_miss,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss,
    input  logic [15:0] d_miss_addr,
    output logic [15:0] mem_addr,
    output logic        mem_en,
    input  logic [15:0] mem_data_in,
    input  logic        mem_data_valid,
    output logic [15:0] fill_data,
    output logic [15:0] fill_addr,
    output logic        i_fill_we,
    output logic        d_fill_we,
    output logic        i_tag_we,
    output logic        d_tag_we,
    output logic        i_fill_done,
    output logic        d_fill_done,
    output logic        busy
);

    import cache_fill_arbiter_pkg::*;

    fillState_e  state_q, state_d;
    cacheSel_e   sel_q, sel_d;
    logic [15:0] base_q, base_d;
    logic        issueDone_q, issueDone_d;

    logic       issueClr, issueInc, issueLast;
    logic       rxClr, rxInc, rxLast;
    logic [2:0] issueCnt, rxCnt;

    fill_word_counter #(.WORDS(BLOCK_WORDS)) u_issue_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (issueClr),
        .inc_i     (issueInc),
        .count_o   (issueCnt),
        .terminal_o(issueLast)
    );

    fill_word_counter #(.WORDS(BLOCK_WORDS)) u_rx_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (rxClr),
        .inc_i     (rxInc),
        .count_o   (rxCnt),
        .terminal_o(rxLast)
    );

    // Returned words are only meaningful in FILL; anything arriving elsewhere is dropped.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        base_d      = base_q;
        issueDone_d = issueDone_q;
        issueClr    = 1'b0;
        issueInc    = 1'b0;
        rxClr       = 1'b0;
        rxInc       = 1'b0;
        mem_en      = 1'b0;
        mem_addr    = '0;
        fill_data   = '0;
        fill_addr   = '0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        i_tag_we    = 1'b0;
        d_tag_we    = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        busy        = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (d_miss || i_miss) begin
                    base_d      = (d_miss ? d_miss_addr : i_miss_addr) & BLOCK_MASK;
                    sel_d       = d_miss ? SEL_D : SEL_I;
                    issueDone_d = 1'b0;
                    issueClr    = 1'b1;
                    rxClr       = 1'b1;
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (!issueDone_q) begin
                    mem_en   = 1'b1;
                    mem_addr = wordAddr(base_q, issueCnt);
                    issueInc = 1'b1;
                    if (issueLast) begin
                        issueDone_d = 1'b1;
                    end
                end
                if (mem_data_valid) begin
                    fill_data = mem_data_in;
                    fill_addr = wordAddr(base_q, rxCnt);
                    i_fill_we = (sel_q == SEL_I);
                    d_fill_we = (sel_q == SEL_D);
                    rxInc     = 1'b1;
                    if (rxLast) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                i_tag_we    = (sel_q == SEL_I);
                d_tag_we    = (sel_q == SEL_D);
                i_fill_done = (sel_q == SEL_I);
                d_fill_done = (sel_q == SEL_D);
                sel_d       = SEL_NONE;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
                sel_d   = SEL_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= SEL_NONE;
            base_q      <= '0;
            issueDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            base_q      <= base_d;
            issueDone_q <= issueDone_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter against a 4-cycle pipelined memory that
// returns each requested word address as its data.
module tb_cache_fill_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_miss;
    logic [15:0] i_miss_addr;
    logic        d_miss;
    logic [15:0] d_miss_addr;
    logic [15:0] mem_addr;
    logic        mem_en;
    logic [15:0] mem_data_in;
    logic        mem_data_valid;
    logic [15:0] fill_data;
    logic [15:0] fill_addr;
    logic        i_fill_we, d_fill_we;
    logic        i_tag_we, d_tag_we;
    logic        i_fill_done, d_fill_done;
    logic        busy;

    logic        spurValid = 1'b0;
    logic [15:0] spurData  = 16'h0000;
    logic [16:0] pipe0 = '0, pipe1 = '0, pipe2 = '0, pipe3 = '0;

    int errors = 0;
    int checks = 0;

    cache_fill_arbiter #(.BLOCK_WORDS(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_miss        (i_miss),
        .i_miss_addr   (i_miss_addr),
        .d_miss        (d_miss),
        .d_miss_addr   (d_miss_addr),
        .mem_addr      (mem_addr),
        .mem_en        (mem_en),
        .mem_data_in   (mem_data_in),
        .mem_data_valid(mem_data_valid),
        .fill_data     (fill_data),
        .fill_addr     (fill_addr),
        .i_fill_we     (i_fill_we),
        .d_fill_we     (d_fill_we),
        .i_tag_we      (i_tag_we),
        .d_tag_we      (d_tag_we),
        .i_fill_done   (i_fill_done),
        .d_fill_done   (d_fill_done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory keeps running through DUT reset so stale returns still arrive afterwards.
    always @(posedge clk) begin
        pipe0 <= {mem_en, mem_addr};
        pipe1 <= pipe0;
        pipe2 <= pipe1;
        pipe3 <= pipe2;
    end

    assign mem_data_valid = pipe3[16] | spurValid;
    assign mem_data_in    = spurValid ? spurData : pipe3[15:0];

    typedef struct {
        logic        iMiss;
        logic        spur;
        logic        busy;
        logic        memEn;
        logic [15:0] memAddr;
        logic        iWe;
        logic [15:0] fillAddr;
        logic        iTag;
        logic        iDone;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic iM, input logic sp, input logic bz, input logic en,
                                input logic [15:0] ma, input logic we, input logic [15:0] fa,
                                input logic tg, input logic dn);
        vec_t v;
        v.iMiss = iM; v.spur = sp; v.busy = bz; v.memEn = en; v.memAddr = ma;
        v.iWe = we; v.fillAddr = fa; v.iTag = tg; v.iDone = dn;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        i_miss    = v.iMiss;
        spurValid = v.spur;
        spurData  = 16'hBEEF;
    endtask

    // Follows one fill from the current cycle until its fill_done (bounded).
    task automatic runFill(input logic isD, input logic [15:0] base);
        int   issued    = 0;
        int   got       = 0;
        logic doneSeen  = 1'b0;
        logic otherSeen = 1'b0;
        for (int cyc = 0; cyc < 40 && !doneSeen; cyc++) begin
            if (mem_en) begin
                checkOutput("issue_addr", mem_addr, base + 16'(2 * issued));
                issued++;
            end
            if (isD ? (i_fill_we | i_tag_we | i_fill_done) : (d_fill_we | d_tag_we | d_fill_done))
                otherSeen = 1'b1;
            if (isD ? d_fill_we : i_fill_we) begin
                checkOutput("fill_addr", fill_addr, base + 16'(2 * got));
                checkOutput("fill_data", fill_data, base + 16'(2 * got));
                got++;
            end
            if (isD ? d_fill_done : i_fill_done) begin
                doneSeen = 1'b1;
                checkOutput("tag_we_with_done", 16'(isD ? d_tag_we : i_tag_we), 16'd1);
            end else begin
                tick();
            end
        end
        checkOutput("fill_done_seen", 16'(doneSeen), 16'd1);
        checkOutput("issue_count", 16'(issued), 16'd8);
        checkOutput("word_count", 16'(got), 16'd8);
        checkOutput("other_cache_quiet", 16'(otherSeen), 16'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen;
        int   words;

        // Lone I miss at 0x1236, offsets relative to acceptance cycle T.
        vecs[0]  = mk(1, 1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);
        vecs[1]  = mk(1, 0, 1, 1, 16'h1230, 0, 16'h0000, 0, 0);
        vecs[2]  = mk(1, 0, 1, 1, 16'h1232, 0, 16'h0000, 0, 0);
        vecs[3]  = mk(1, 0, 1, 1, 16'h1234, 0, 16'h0000, 0, 0);
        vecs[4]  = mk(1, 0, 1, 1, 16'h1236, 0, 16'h0000, 0, 0);
        vecs[5]  = mk(1, 0, 1, 1, 16'h1238, 1, 16'h1230, 0, 0);
        vecs[6]  = mk(1, 0, 1, 1, 16'h123A, 1, 16'h1232, 0, 0);
        vecs[7]  = mk(1, 0, 1, 1, 16'h123C, 1, 16'h1234, 0, 0);
        vecs[8]  = mk(1, 0, 1, 1, 16'h123E, 1, 16'h1236, 0, 0);
        vecs[9]  = mk(1, 0, 1, 0, 16'h0000, 1, 16'h1238, 0, 0);
        vecs[10] = mk(1, 0, 1, 0, 16'h0000, 1, 16'h123A, 0, 0);
        vecs[11] = mk(1, 0, 1, 0, 16'h0000, 1, 16'h123C, 0, 0);
        vecs[12] = mk(1, 0, 1, 0, 16'h0000, 1, 16'h123E, 0, 0);
        vecs[13] = mk(1, 1, 1, 0, 16'h0000, 0, 16'h0000, 1, 1);
        vecs[14] = mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);

        rst_n = 1'b0; i_miss = 1'b0; d_miss = 1'b0;
        i_miss_addr = 16'h0000; d_miss_addr = 16'h0000;
        tick();
        tick();
        checkOutput("reset_busy", 16'(busy), 16'd0);
        checkOutput("reset_mem_en", 16'(mem_en), 16'd0);
        checkOutput("reset_mem_addr", mem_addr, 16'h0000);
        checkOutput("reset_fill_data", fill_data, 16'h0000);
        checkOutput("reset_fill_addr", fill_addr, 16'h0000);
        checkOutput("reset_strobes", {10'd0, i_fill_we, d_fill_we, i_tag_we, d_tag_we, i_fill_done, d_fill_done}, 16'h0000);
        rst_n = 1'b1;
        tick();

        i_miss_addr = 16'h1236;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) tick();
            applyStimulus(vecs[k]);
            #1;
            checkOutput($sformatf("v%0d_busy", k), 16'(busy), 16'(vecs[k].busy));
            checkOutput($sformatf("v%0d_mem_en", k), 16'(mem_en), 16'(vecs[k].memEn));
            if (vecs[k].memEn)
                checkOutput($sformatf("v%0d_mem_addr", k), mem_addr, vecs[k].memAddr);
            checkOutput($sformatf("v%0d_i_fill_we", k), 16'(i_fill_we), 16'(vecs[k].iWe));
            if (vecs[k].iWe) begin
                checkOutput($sformatf("v%0d_fill_addr", k), fill_addr, vecs[k].fillAddr);
                checkOutput($sformatf("v%0d_fill_data", k), fill_data, vecs[k].fillAddr);
            end
            checkOutput($sformatf("v%0d_i_tag_we", k), 16'(i_tag_we), 16'(vecs[k].iTag));
            checkOutput($sformatf("v%0d_i_fill_done", k), 16'(i_fill_done), 16'(vecs[k].iDone));
            checkOutput($sformatf("v%0d_d_quiet", k), {13'd0, d_fill_we, d_tag_we, d_fill_done}, 16'd0);
        end

        // Simultaneous misses: D first, then I in the IDLE cycle after D completes.
        tick();
        i_miss_addr = 16'h0040; d_miss_addr = 16'h8008;
        i_miss = 1'b1; d_miss = 1'b1;
        #1;
        checkOutput("both_accept_busy", 16'(busy), 16'd0);
        tick();
        runFill(1'b1, 16'h8000);
        tick();
        d_miss = 1'b0;
        #1;
        checkOutput("idle_gap_busy", 16'(busy), 16'd0);
        tick();
        checkOutput("i_accept_next_idle", 16'(busy), 16'd1);
        runFill(1'b0, 16'h0040);
        tick();
        i_miss = 1'b0;

        // Top block of the address space, with the miss dropped mid-fill.
        tick();
        d_miss_addr = 16'hFFFA; d_miss = 1'b1;
        tick();
        d_miss = 1'b0;
        #1;
        runFill(1'b1, 16'hFFF0);
        tick();

        // Reset during the 4th returned word, then stale returns, then a clean fill.
        tick();
        i_miss_addr = 16'h2000; i_miss = 1'b1;
        tick();
        words = 0;
        for (int cyc = 0; cyc < 30 && words < 4; cyc++) begin
            if (i_fill_we) words++;
            if (words < 4) tick();
        end
        checkOutput("reach_4th_word", 16'(words), 16'd4);
        rst_n = 1'b0;
        i_miss = 1'b0;
        #1;
        checkOutput("midreset_busy", 16'(busy), 16'd0);
        checkOutput("midreset_mem_en", 16'(mem_en), 16'd0);
        checkOutput("midreset_mem_addr", mem_addr, 16'h0000);
        checkOutput("midreset_fill_data", fill_data, 16'h0000);
        checkOutput("midreset_fill_addr", fill_addr, 16'h0000);
        checkOutput("midreset_strobes", {10'd0, i_fill_we, d_fill_we, i_tag_we, d_tag_we, i_fill_done, d_fill_done}, 16'h0000);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            tick();
            if (i_fill_we | d_fill_we | i_tag_we | d_tag_we | i_fill_done | d_fill_done | busy)
                seen = 1'b1;
        end
        checkOutput("stale_returns_ignored", 16'(seen), 16'd0);
        d_miss_addr = 16'h3004; d_miss = 1'b1;
        tick();
        runFill(1'b1, 16'h3000);
        tick();
        d_miss = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
